pwm_duty_decoder: RTL and testbench
===================================

# pwm_duty_decoder

Recovers the duty-cycle level (0..10) of one RGB channel's PWM waveform by sampling it against the shared main PWM counter. It is the receive-side counterpart of the per-colour duty generator, which drives a channel high while `MAIN_CNT < duty`. The block sits on the LED output path and feeds self-test, readback and status logic. It reports each completed period's level, flags malformed waveforms, and indicates when the level has settled.

## Interface
Parameters:
- `PERIOD`, 10: PWM slots per period; `MAIN_CNT` runs 0..PERIOD-1.
- `SYNC_STAGES`, 2: flop stages applied to `PWM_IN` and, for alignment, to `MAIN_CNT`. Range 1..3.
- `STABLE_CNT`, 3: consecutive equal valid results required before `STABLE` asserts.
- `ACTIVE_LOW`, 0: if 1, `PWM_IN` is inverted before sampling (common-anode pin).

Ports:
- `CLK`  in  1: system clock, rising edge.
- `CLR_N`  in  1: reset, asynchronous, active-low.
- `MAIN_CNT`  in  4: shared main PWM counter, 0..PERIOD-1.
- `PWM_IN`  in  1: channel waveform under measurement.
- `DUTY`  out  4: last valid measured level, 0..PERIOD.
- `DUTY_VLD`  out  1: one-cycle pulse when `DUTY` updates.
- `CHANGED`  out  1: one-cycle pulse, coincident with `DUTY_VLD`, when the new `DUTY` differs from the previous valid one.
- `STABLE`  out  1: level.
- `GLITCH`  out  1: one-cycle pulse, malformed period discarded.
- `SEQ_ERR`  out  1: one-cycle pulse, `MAIN_CNT` stepped out of order.

## Operation
- Aligned signals: `pwm_a` is the synchronised (and optionally inverted) `PWM_IN`; `cnt_a` is `MAIN_CNT` delayed by the same `SYNC_STAGES`.
- Slot start: a cycle where `cnt_a != cnt_prev` (`cnt_prev` is a register). The block samples `pwm_a` only at slot starts, once per slot regardless of the prescale.
- Legal step: `cnt_a == cnt_prev+1`, or `cnt_prev == PERIOD-1` and `cnt_a == 0`. Any other slot start is illegal:
  - pulse `SEQ_ERR`;
  - discard the accumulation;
  - clear the stable run;
  - go to SEEK.
- FSM states:
  - **SEEK**: wait for a legal wrap to slot 0, then go to HIGH with `hcnt = pwm_a`. If `pwm_a` = 0, go to LOW with `hcnt = 0`.
  - **HIGH**: at each slot start, `pwm_a`=1 gives `hcnt++`; `pwm_a`=0 gives LOW.
  - **LOW**: at each slot start, `pwm_a`=1 gives `GLITCH` pulse and moves to DISCARD.
  - **DISCARD**: ignore samples until the next wrap.
  - On a wrap (new slot 0) from HIGH or LOW:
    - commit `hcnt` as the result;
    - begin the next period, sampling slot 0 into the new `hcnt` in the same cycle.
  - On a wrap from DISCARD, restart as from SEEK.
- Commit rules:
  - `DUTY <= hcnt`; pulse `DUTY_VLD`.
  - Pulse `CHANGED` if `hcnt != DUTY` and at least one prior valid result exists.
  - Run counter: increment if equal, saturating at `STABLE_CNT`; otherwise reset it to 1.
  - `STABLE = (run == STABLE_CNT)`.
- Width: `hcnt` is 4 bits and saturates at PERIOD. Duty 0 gives all-low, so the result is 0. Duty PERIOD gives all-high, so the result is PERIOD.
- The first partial period after reset is never reported, because SEEK waits for a wrap.
- `GLITCH` or `SEQ_ERR` clears the run counter and `STABLE`. `DUTY` holds its last valid value.
- Simultaneous events: an illegal step and a glitch on the same slot start report `SEQ_ERR` only.

## Timing
- Reset values: `DUTY`=0, `DUTY_VLD`=0, `CHANGED`=0, `STABLE`=0, `GLITCH`=0, `SEQ_ERR`=0. FSM resets to SEEK, counters to 0, and the sync chain to 0.
- Reset asserted mid-period clears everything immediately. After release, the first result needs one full period plus the partial period.
- Result latency: `DUTY`/`DUTY_VLD` update on the edge `SYNC_STAGES+1` edges after the edge on which `MAIN_CNT` first presents 0 following PERIOD-1.
- `GLITCH`/`SEQ_ERR` are registered, `SYNC_STAGES+1` edges after the offending `MAIN_CNT` or `PWM_IN` change.
- Minimum slot length is 1 cycle (MAIN_CNT may advance every cycle).
- All pulse outputs are exactly one cycle wide.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_PERIOD` = 10;
  - `DUTY_W` = 4;
  - FSM enum `dec_state_t` {SEEK, HIGH, LOW, DISCARD}.
  The generator side uses the same period and width constants.
- Sub-module `pwm_sync`: a parameterised `SYNC_STAGES` flop chain carrying `{MAIN_CNT, PWM_IN}` together so the two stay aligned.

## Test plan
- Generator model, duty 7, MAIN_CNT advancing every 4 cycles for 5 periods -> `DUTY`=7. `DUTY_VLD` pulses once per period; `STABLE` rises on the 3rd result; `CHANGED` never pulses.
- Duty 0, then duty 10, for 3 periods each -> results 0,0,0 then 10,10,10. `CHANGED` pulses once, at the first 10; `STABLE` drops, then reasserts.
- Duty 5 with an injected high at slot 8 -> `GLITCH` pulses once and that period is not reported. The next clean period gives `DUTY`=5 and run = 1.
- MAIN_CNT jumps 3->6 -> `SEQ_ERR` pulses and `STABLE`=0. The first result after that arrives at the second wrap.
- `CLR_N` low mid-period with `DUTY`=7 -> all outputs 0 asynchronously. After release, no `DUTY_VLD` until the first wrap-to-wrap period completes.
- `ACTIVE_LOW`=1 with an inverted duty-3 waveform, `SYNC_STAGES`=3 -> `DUTY`=3, with the measured latency equal to 4 edges after MAIN_CNT wraps to 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM constants and decoder state encoding.
// Used by the duty generator and the duty decoder.
package pwm_pkg;

  localparam int PWM_PERIOD = 10;
  localparam int DUTY_W     = 4;

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW,
    DISCARD
  } dec_state_t;

  function automatic logic [DUTY_W-1:0] sat_inc(
    input logic [DUTY_W-1:0] v,
    input logic [DUTY_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Flop chain carrying counter and waveform together
// so both arrive at the decoder on the same edge.
module pwm_sync #(
  parameter int STAGES = 2,
  parameter int W      = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '{default: '0};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty level of one PWM channel by sampling
// it once per slot of the shared main counter.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 3,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DUTY_W-1:0] MAIN_CNT,
  input  logic              PWM_IN,
  output logic [DUTY_W-1:0] DUTY,
  output logic              DUTY_VLD,
  output logic              CHANGED,
  output logic              STABLE,
  output logic              GLITCH,
  output logic              SEQ_ERR
);

  localparam int RW = $clog2(STABLE_CNT + 1);
  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] PMAX = DUTY_W'(PERIOD);
  localparam logic [RW-1:0]     RMAX = RW'(STABLE_CNT);

  logic [DUTY_W-1:0] cnt_a, cnt_prev;
  logic              pwm_s, pwm_a;
  logic [DUTY_W:0]   cnt_nxt;
  logic              slot, legal, wrap;

  dec_state_t        state, state_n;
  logic [DUTY_W-1:0] hcnt, hcnt_n;
  logic [DUTY_W-1:0] duty_n;
  logic [RW-1:0]     run, run_n;
  logic              have_vld, have_n;
  logic              vld_n, chg_n, glitch_n, seq_n;
  logic              commit, start;

  pwm_sync #(
    .STAGES(SYNC_STAGES),
    .W     (DUTY_W + 1)
  ) u_sync (
    .clk  (CLK),
    .rst_n(CLR_N),
    .d    ({MAIN_CNT, PWM_IN}),
    .q    ({cnt_a, pwm_s})
  );

  assign pwm_a   = pwm_s ^ (ACTIVE_LOW != 0);
  assign cnt_nxt = {1'b0, cnt_prev} + 1'b1;
  assign slot    = cnt_a != cnt_prev;
  assign legal   = (cnt_nxt == {1'b0, cnt_a}) ||
                   (cnt_prev == LAST && cnt_a == '0);
  assign wrap    = slot && legal && cnt_a == '0;

  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    duty_n   = DUTY;
    run_n    = run;
    have_n   = have_vld;
    vld_n    = 1'b0;
    chg_n    = 1'b0;
    glitch_n = 1'b0;
    seq_n    = 1'b0;
    commit   = 1'b0;
    start    = 1'b0;
    if (slot && !legal) begin
      seq_n   = 1'b1;
      run_n   = '0;
      hcnt_n  = '0;
      state_n = SEEK;
    end else if (slot) begin
      unique case (state)
        SEEK, DISCARD: start = wrap;
        HIGH: begin
          if (wrap) begin
            commit = 1'b1;
            start  = 1'b1;
          end else if (pwm_a) begin
            hcnt_n = sat_inc(hcnt, PMAX);
          end else begin
            state_n = LOW;
          end
        end
        LOW: begin
          if (wrap) begin
            commit = 1'b1;
            start  = 1'b1;
          end else if (pwm_a) begin
            glitch_n = 1'b1;
            run_n    = '0;
            state_n  = DISCARD;
          end
        end
      endcase
    end
    if (commit) begin
      duty_n = hcnt;
      vld_n  = 1'b1;
      chg_n  = have_vld && (hcnt != DUTY);
      have_n = 1'b1;
      if (hcnt != DUTY) run_n = RW'(1);
      else if (run != RMAX) run_n = run + 1'b1;
    end
    // slot 0 of the new period is sampled on the wrap itself
    if (start) begin
      state_n = pwm_a ? HIGH : LOW;
      hcnt_n  = DUTY_W'(pwm_a);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state    <= SEEK;
      cnt_prev <= '0;
      hcnt     <= '0;
      run      <= '0;
      have_vld <= 1'b0;
      DUTY     <= '0;
      DUTY_VLD <= 1'b0;
      CHANGED  <= 1'b0;
      GLITCH   <= 1'b0;
      SEQ_ERR  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt_prev <= cnt_a;
      hcnt     <= hcnt_n;
      run      <= run_n;
      have_vld <= have_n;
      DUTY     <= duty_n;
      DUTY_VLD <= vld_n;
      CHANGED  <= chg_n;
      GLITCH   <= glitch_n;
      SEQ_ERR  <= seq_n;
    end
  end

  assign STABLE = run == RMAX;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: default instance
// plus an active-low, three-stage-sync instance.
module tb_pwm_duty_decoder;

  typedef struct {
    logic [3:0] d;
    logic       chg;
    logic       stb;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic [3:0] MAIN_CNT = '0;
  logic       PWM_IN = 1'b0;
  logic [3:0] DUTY;
  logic       DUTY_VLD, CHANGED, STABLE, GLITCH, SEQ_ERR;

  logic [3:0] cnt2 = '0;
  logic       pwm2 = 1'b1;
  logic [3:0] duty2;
  logic       vld2, chg2, stb2, gl2, se2;

  int n_checks = 0;
  int n_pass = 0;
  int n_glitch = 0, n_seq = 0, n_vld = 0, n_vld2 = 0;
  int exp_glitch = 0, exp_seq = 0;

  exp_t q[$];
  exp_t mon_e;

  int last_cnt = 0;
  bit cur_ok = 0, prev_valid = 0, have = 0;
  int prev_duty = 0, last_dut = 0, run = 0;

  always #5 CLK = ~CLK;

  pwm_duty_decoder u_dut (
    .CLK(CLK), .CLR_N(CLR_N), .MAIN_CNT(MAIN_CNT), .PWM_IN(PWM_IN),
    .DUTY(DUTY), .DUTY_VLD(DUTY_VLD), .CHANGED(CHANGED),
    .STABLE(STABLE), .GLITCH(GLITCH), .SEQ_ERR(SEQ_ERR)
  );

  pwm_duty_decoder #(.SYNC_STAGES(3), .ACTIVE_LOW(1)) u_dut2 (
    .CLK(CLK), .CLR_N(CLR_N), .MAIN_CNT(cnt2), .PWM_IN(pwm2),
    .DUTY(duty2), .DUTY_VLD(vld2), .CHANGED(chg2),
    .STABLE(stb2), .GLITCH(gl2), .SEQ_ERR(se2)
  );

  always @(negedge CLK) begin
    if (DUTY_VLD) begin
      n_vld++;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_vld duty=%0d", DUTY);
      end else begin
        mon_e = q.pop_front();
        if ({DUTY, CHANGED, STABLE} !== {mon_e.d, mon_e.chg, mon_e.stb})
          $display("FAIL result got duty=%0d chg=%b stb=%b want duty=%0d chg=%b stb=%b",
                   DUTY, CHANGED, STABLE, mon_e.d, mon_e.chg, mon_e.stb);
        else n_pass++;
      end
    end else if (CHANGED) begin
      n_checks++;
      $display("FAIL changed_without_vld got 1 want 0");
    end
    if (GLITCH) n_glitch++;
    if (SEQ_ERR) n_seq++;
    if (vld2) n_vld2++;
  end

  task automatic commit(input int d);
    exp_t e;
    e.d = 4'(d);
    e.chg = have && d != last_dut;
    if (d != last_dut) run = 1;
    else if (run < 3) run++;
    e.stb = run == 3;
    have = 1;
    last_dut = d;
    q.push_back(e);
  endtask

  task automatic slot(input int c, input bit p, input int presc);
    if (c != last_cnt) begin
      if (!(c == last_cnt + 1 || (last_cnt == 9 && c == 0))) begin
        exp_seq++;
        run = 0;
        cur_ok = 0;
        prev_valid = 0;
      end else if (c == 0) begin
        if (prev_valid) commit(prev_duty);
        cur_ok = 1;
      end
    end
    last_cnt = c;
    MAIN_CNT = 4'(c);
    PWM_IN = p;
    repeat (presc) @(posedge CLK);
    #1;
  endtask

  task automatic run_period(input int duty, input int gslot, input int presc);
    bit p;
    for (int s = 0; s < 10; s++) begin
      p = (s < duty) || (s == gslot);
      slot(s, p, presc);
      if (s == gslot && gslot > duty && cur_ok) begin
        exp_glitch++;
        run = 0;
        cur_ok = 0;
      end
    end
    prev_valid = cur_ok;
    prev_duty = duty;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge CLK);
      #1;
      t++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL drain pending got %0d want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({DUTY, DUTY_VLD, CHANGED, STABLE, GLITCH, SEQ_ERR} !== 9'd0)
      $display("FAIL reset_outputs got %h want 0",
               {DUTY, DUTY_VLD, CHANGED, STABLE, GLITCH, SEQ_ERR});
    else n_pass++;
    repeat (3) @(posedge CLK);
    #1;
    CLR_N = 1'b1;
  endtask

  task automatic test_duty7();
    int v0 = n_vld;
    for (int i = 0; i < 5; i++) run_period(7, -1, 4);
    drain();
    n_checks++;
    if (n_vld - v0 != 3) $display("FAIL duty7_vld_count got %0d want 3", n_vld - v0);
    else n_pass++;
    n_checks++;
    if (STABLE !== 1'b1) $display("FAIL duty7_stable got %b want 1", STABLE);
    else n_pass++;
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 3; i++) run_period(0, -1, 4);
    for (int i = 0; i < 3; i++) run_period(10, -1, 4);
    drain();
    n_checks++;
    if (DUTY !== 4'd10) $display("FAIL extremes_duty got %0d want 10", DUTY);
    else n_pass++;
  endtask

  task automatic test_glitch();
    run_period(5, 8, 4);
    run_period(5, -1, 4);
    run_period(5, -1, 4);
    drain();
    n_checks++;
    if (n_glitch !== exp_glitch)
      $display("FAIL glitch_count got %0d want %0d", n_glitch, exp_glitch);
    else n_pass++;
    n_checks++;
    if (DUTY !== 4'd5) $display("FAIL glitch_duty got %0d want 5", DUTY);
    else n_pass++;
  endtask

  task automatic test_seq_err();
    int js[8] = '{0, 1, 2, 3, 6, 7, 8, 9};
    run_period(5, -1, 4);
    foreach (js[i]) slot(js[i], js[i] < 5, 4);
    prev_valid = cur_ok;
    prev_duty = 5;
    n_checks++;
    if (STABLE !== 1'b0) $display("FAIL seq_stable got %b want 0", STABLE);
    else n_pass++;
    n_checks++;
    if (n_seq !== exp_seq) $display("FAIL seq_count got %0d want %0d", n_seq, exp_seq);
    else n_pass++;
    run_period(5, -1, 4);
    run_period(5, -1, 4);
    drain();
  endtask

  task automatic test_reset_mid();
    int v0;
    for (int i = 0; i < 3; i++) run_period(7, -1, 4);
    for (int s = 0; s < 5; s++) slot(s, s < 7, 4);
    drain();
    n_checks++;
    if (DUTY !== 4'd7) $display("FAIL pre_reset_duty got %0d want 7", DUTY);
    else n_pass++;
    CLR_N = 1'b0;
    #1;
    n_checks++;
    if ({DUTY, DUTY_VLD, CHANGED, STABLE, GLITCH, SEQ_ERR} !== 9'd0)
      $display("FAIL async_reset got %h want 0",
               {DUTY, DUTY_VLD, CHANGED, STABLE, GLITCH, SEQ_ERR});
    else n_pass++;
    have = 0; last_dut = 0; run = 0;
    prev_valid = 0; cur_ok = 0; last_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    CLR_N = 1'b1;
    v0 = n_vld;
    for (int s = 5; s < 10; s++) slot(s, s < 7, 4);
    prev_valid = cur_ok;
    run_period(7, -1, 4);
    n_checks++;
    if (n_vld != v0) $display("FAIL early_vld got %0d want 0", n_vld - v0);
    else n_pass++;
    run_period(7, -1, 4);
    drain();
    n_checks++;
    if (n_vld - v0 != 1) $display("FAIL post_reset_vld got %0d want 1", n_vld - v0);
    else n_pass++;
    n_checks++;
    if (n_seq !== exp_seq) $display("FAIL reset_seq_count got %0d want %0d", n_seq, exp_seq);
    else n_pass++;
  endtask

  task automatic test_active_low();
    int v0 = n_vld2;
    for (int per = 0; per < 3; per++) begin
      for (int s = 0; s < 10; s++) begin
        cnt2 = 4'(s);
        pwm2 = !(s < 3);
        if (per == 2 && s == 0) begin
          for (int e = 1; e <= 4; e++) begin
            @(posedge CLK);
            #1;
            if (e == 3) begin
              n_checks++;
              if (vld2 !== 1'b0) $display("FAIL latency_early got %b want 0", vld2);
              else n_pass++;
            end
            if (e == 4) begin
              n_checks++;
              if ({vld2, duty2} !== {1'b1, 4'd3})
                $display("FAIL latency_result got vld=%b duty=%0d want vld=1 duty=3",
                         vld2, duty2);
              else n_pass++;
            end
          end
        end else begin
          repeat (2) @(posedge CLK);
          #1;
        end
      end
    end
    n_checks++;
    if (n_vld2 - v0 != 1) $display("FAIL al_vld_count got %0d want 1", n_vld2 - v0);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_duty7();
    test_extremes();
    test_glitch();
    test_seq_err();
    test_reset_mid();
    test_active_low();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
